load_ext_unit: RTL and testbench

- Load-side counterpart of the store byte-enable logic: services lb/lbu/lh/lhu/lw.
- Issues a word read to data memory over a req/ack handshake and captures the returned word.
- Selects the byte or halfword by addr[1:0], then sign- or zero-extends it into a 32-bit writeback value.
- Sits between the EX-stage address/opcode and the register-file writeback mux; stalls the CPU while busy.

---
 rtl/load_ext_unit_pkg.sv | 37 +++
 rtl/load_ext_unit_if.sv | 36 +++
 rtl/load_data_ext.sv | 49 ++++
 rtl/load_ext_unit.sv | 138 +++++++++++++
 tb/tb_load_ext_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/load_ext_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_ext_unit_pkg
// Purpose  : Shared load/store opcode encodings (instr[31:26]) and small
//            helpers used by the load extension unit.
// Contents : OP_LB/OP_LH/OP_LW/OP_LBU/OP_LHU next to OP_SB/OP_SH/OP_SW,
//            is_load(), is_misaligned().
// Revision : 1.0 - initial release
// ============================================================================
package load_ext_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  // Halfwords must sit on an even byte, words on a multiple of four.
  function automatic logic is_misaligned(input logic [5:0] op,
                                         input logic [1:0] off);
    logic w_mis;
    w_mis = 1'b0;
    if ((op == OP_LH) || (op == OP_LHU)) w_mis = off[0];
    else if (op == OP_LW)                w_mis = |off;
    return w_mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_ext_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_ext_unit_if
// Purpose  : Bundles the core-side load handshake and the data-memory read
//            handshake of the load extension unit.
// Ports    : core side  - ld_valid, ld_ready, OP, addr, ld_done, ld_data,
//                         ld_err
//            memory side - mem_req, mem_addr, mem_ack, mem_rdata
// Modports : slave  - the load unit itself
//            master - its environment (core + data memory)
// Revision : 1.0 - initial release
// ============================================================================
interface load_ext_unit_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [5:0]  OP;
  logic [31:0] addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        ld_err;

  modport slave (
    input  ld_valid, OP, addr, mem_ack, mem_rdata,
    output ld_ready, mem_req, mem_addr, ld_done, ld_data, ld_err
  );

  modport master (
    output ld_valid, OP, addr, mem_ack, mem_rdata,
    input  ld_ready, mem_req, mem_addr, ld_done, ld_data, ld_err
  );
endinterface
`default_nettype wire

// File: rtl/load_data_ext.sv
`default_nettype none
// ============================================================================
// Module   : load_data_ext
// Purpose  : Combinational byte/halfword select and sign/zero extension of a
//            little-endian memory word for lb/lbu/lh/lhu/lw.
// Ports    : OP   in  6  load opcode
//            off  in  2  byte offset within the word (addr[1:0])
//            word in 32  raw memory word
//            data out 32 extended load value (0 for a non-load OP)
// Revision : 1.0 - initial release
// ============================================================================
module load_data_ext
  import load_ext_unit_pkg::*;
(
  input  logic [5:0]  OP,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[7:0];
    case (off)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    // off[0] is deliberately ignored: misaligned halfwords truncate down.
    w_half = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = 32'd0;
    case (OP)
      OP_LB:   data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  data = {24'd0, w_byte};
      OP_LH:   data = {{16{w_half[15]}}, w_half};
      OP_LHU:  data = {16'd0, w_half};
      OP_LW:   data = word;
      default: data = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_ext_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_ext_unit
// Purpose  : Services lb/lbu/lh/lhu/lw: issues a word read over req/ack,
//            extracts and extends the addressed byte/halfword/word, and
//            returns it with a one-cycle ld_done pulse. Stalls the core while
//            busy (ld_ready low outside IDLE).
// Ports    : clk  - system clock, rising edge
//            rstn - asynchronous active-low reset
//            bus  - load_ext_unit_if.slave (core + memory handshakes)
// Params   : TIMEOUT_CYC - REQ cycles without mem_ack before erroring (>=1)
//            CNT_W       - wait counter width, 2**CNT_W > TIMEOUT_CYC
// Config   : LOAD_MISALIGN_TRAP_EN - when defined, misaligned lh/lhu/lw skip
//            memory and complete immediately with ld_err.
// Revision : 1.0 - initial release
// ============================================================================
module load_ext_unit
  import load_ext_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rstn,
  load_ext_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_op;
  logic [1:0]         r_off;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_ld_data;
  logic               r_err;

  logic               w_accept;
  logic               w_capture;
  logic               w_fail;
  logic               w_misal;
  logic               w_timeout;
  logic [31:0]        w_ext;

`ifdef LOAD_MISALIGN_TRAP_EN
  assign w_misal = is_misaligned(bus.OP, bus.addr[1:0]);
`else
  assign w_misal = 1'b0;
`endif

  // Last permitted wait cycle; an ack on this same cycle still wins.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  load_data_ext u_ext (
    .OP   (r_op),
    .off  (r_off),
    .word (bus.mem_rdata),
    .data (w_ext)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_fail    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.ld_valid) begin
          if (is_load(bus.OP) && !w_misal) begin
            w_next   = ST_REQ;
            w_accept = 1'b1;
          end else begin
            w_next = ST_DONE;
            w_fail = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          w_next    = ST_DONE;
          w_capture = 1'b1;
        end else if (w_timeout) begin
          w_next = ST_DONE;
          w_fail = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op       <= 6'd0;
      r_off      <= 2'd0;
      r_cnt      <= '0;
      r_mem_addr <= 32'd0;
      r_ld_data  <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op       <= bus.OP;
        r_off      <= bus.addr[1:0];
        r_mem_addr <= {bus.addr[31:2], 2'b00};
        r_cnt      <= '0;
      end else if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_ld_data <= w_ext;
        r_err     <= 1'b0;
      end else if (w_fail) begin
        r_ld_data <= 32'd0;
        r_err     <= 1'b1;
      end
    end
  end

  // Decoded straight from the state register so mem_req drops with reset.
  assign bus.ld_ready = (r_state == ST_IDLE);
  assign bus.mem_req  = (r_state == ST_REQ);
  assign bus.mem_addr = r_mem_addr;
  assign bus.ld_done  = (r_state == ST_DONE);
  assign bus.ld_err   = (r_state == ST_DONE) && r_err;
  assign bus.ld_data  = r_ld_data;

endmodule
`default_nettype wire

// File: tb/tb_load_ext_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_ext_unit
// Purpose  : Self-checking bench for load_ext_unit: directed loads, timeout,
//            reset during a request, stray acks, then randomized loads
//            compared against an arithmetic reference model.
// Config   : honours LOAD_MISALIGN_TRAP_EN to select the expected behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_ext_unit;
  import load_ext_unit_pkg::*;

  localparam int TO = 16;
`ifdef LOAD_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  logic [31:0] last_data = 32'd0;

  load_ext_unit_if bus ();

  load_ext_unit #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_is_load(input logic [5:0] op);
    return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
  endfunction

  function automatic bit model_misal(input logic [5:0] op, input logic [31:0] a);
    if (op == OP_LH || op == OP_LHU) return (a % 2) != 0;
    if (op == OP_LW) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Value the core should see, computed with shifts/modulo on the word.
  function automatic logic [31:0] ref_ext(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] w);
    int unsigned off, b, h;
    off = a % 4;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    if (op == OP_LB)  return (b >= 128) ? b - 256 : b;
    if (op == OP_LBU) return b;
    if (op == OP_LH)  return (h >= 32768) ? h - 65536 : h;
    if (op == OP_LHU) return h;
    if (op == OP_LW)  return w;
    return 32'd0;
  endfunction

  // d = REQ-cycle index (0-based) on which ack is driven; d >= TO means never.
  task automatic do_load(input logic [5:0] op, input logic [31:0] a, input int d,
                         input logic [31:0] w);
    logic [31:0] exp_d;
    logic        exp_e;
    bit          mem_path;
    bit          fin;
    int          cyc;
    check("ready_idle", bus.ld_ready, 1);
    bus.ld_valid = 1'b1;
    bus.OP       = op;
    bus.addr     = a;
    tick();
    bus.ld_valid = 1'b0;
    bus.OP       = 6'($urandom);
    bus.addr     = $urandom;
    mem_path = model_is_load(op) && !(TRAP && model_misal(op, a));
    if (!mem_path || d >= TO) begin
      exp_e = 1'b1;
      exp_d = 32'd0;
    end else begin
      exp_e = 1'b0;
      exp_d = ref_ext(op, a, w);
    end
    if (mem_path) begin
      cyc = 0;
      fin = 1'b0;
      while (!fin) begin
        check("mem_req_hi", bus.mem_req, 1);
        check("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
        check("ready_busy", bus.ld_ready, 0);
        check("done_busy", bus.ld_done, 0);
        check("data_hold", bus.ld_data, last_data);
        if (cyc == d) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = w;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
        tick();
        bus.mem_ack = 1'b0;
        if (cyc == d || cyc == TO - 1) fin = 1'b1;
        cyc++;
      end
    end
    check("done_pulse", bus.ld_done, 1);
    check("err", bus.ld_err, exp_e);
    check("data", bus.ld_data, exp_d);
    check("mem_req_lo", bus.mem_req, 0);
    check("ready_done", bus.ld_ready, 0);
    last_data = exp_d;
    tick();
    check("done_end", bus.ld_done, 0);
    check("err_end", bus.ld_err, 0);
    check("ready_back", bus.ld_ready, 1);
    check("data_keep", bus.ld_data, last_data);
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SW, 6'h00};
    bus.ld_valid  = 1'b0;
    bus.OP        = 6'd0;
    bus.addr      = 32'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    rstn          = 1'b0;
    tick();
    tick();
    check("rst_ready", bus.ld_ready, 1);
    check("rst_req", bus.mem_req, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_done", bus.ld_done, 0);
    check("rst_data", bus.ld_data, 0);
    check("rst_err", bus.ld_err, 0);
    rstn = 1'b1;
    tick();

    // Directed loads.
    do_load(OP_LB, 32'h1000_0001, 0, 32'h1234_80FF);
    check("lb_const", bus.ld_data, 32'hFFFF_FF80);
    do_load(OP_LBU, 32'h1000_0003, 1, 32'h1234_80FF);
    check("lbu_const", bus.ld_data, 32'h0000_0012);
    do_load(OP_LHU, 32'h1000_0002, 0, 32'h1234_80FF);
    check("lhu_const", bus.ld_data, 32'h0000_1234);
    do_load(OP_LH, 32'h1000_0000, 2, 32'h0000_8001);
    check("lh_const", bus.ld_data, 32'hFFFF_8001);
    do_load(OP_LW, 32'h2000_0004, 5, 32'hDEAD_BEEF);
    check("lw_const", bus.ld_data, 32'hDEAD_BEEF);
    do_load(OP_LW, 32'h2000_0008, TO + 3, 32'h1111_1111);
    check("timeout_const", bus.ld_data, 32'd0);
    do_load(OP_LW, 32'h2000_000C, TO - 1, 32'h5A5A_A5A5);
    check("lastack_const", bus.ld_data, 32'h5A5A_A5A5);
    do_load(OP_SW, 32'h3000_0000, 0, 32'h0);
    do_load(OP_LW, 32'h3000_0002, 0, 32'hCAFE_BABE);
    check("lw_mis_const", bus.ld_data, TRAP ? 32'd0 : 32'hCAFE_BABE);
    do_load(OP_LH, 32'h3000_0003, 0, 32'h8765_4321);

    // Stray ack in IDLE must be ignored.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_ack = 1'b0;
    check("stray_done", bus.ld_done, 0);
    check("stray_ready", bus.ld_ready, 1);
    check("stray_data", bus.ld_data, last_data);
    check("stray_req", bus.mem_req, 0);

    // Reset pulse while a request is outstanding.
    bus.ld_valid = 1'b1;
    bus.OP       = OP_LW;
    bus.addr     = 32'h4000_0010;
    tick();
    bus.ld_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_req", bus.mem_req, 1);
    rstn = 1'b0;
    #1;
    check("async_req", bus.mem_req, 0);
    check("async_ready", bus.ld_ready, 1);
    check("async_data", bus.ld_data, 0);
    tick();
    rstn = 1'b1;
    last_data = 32'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_done", bus.ld_done, 0);
      check("post_rst_req", bus.mem_req, 0);
    end
    do_load(OP_LW, 32'h4000_0020, 2, 32'h0BAD_F00D);

    // Randomized loads.
    for (int n = 0; n < 300; n++) begin
      logic [5:0]  op;
      int          d;
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 4)];
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 4) : $urandom_range(0, 4);
      do_load(op, $urandom, d, $urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
